// File: rtl/ber_pkg.sv
// ber_pkg: shared definitions for the bit-error-rate counter.
//   - ber_state_e : SEARCH (sweeping reference delay taps) / COUNT (locked).
//   - DEF_*       : default DELAY_LEN, WINDOW and CNT_W.
//   - sat_inc     : counter increment on a MAX_CNT_W-wide container.
//                   Its overflow behaviour depends on the BER_COUNT_SAT_EN macro.
//                   Defined: the counter saturates at max_val and holds.
//                   Undefined: the counter wraps modulo (max_val+1).
package ber_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    COUNT  = 1'b1
  } ber_state_e;

  localparam int unsigned DEF_DELAY_LEN = 512;
  localparam int unsigned DEF_WINDOW    = 511;
  localparam int unsigned DEF_CNT_W     = 64;

  // Widest counter the increment helper supports.
  localparam int unsigned MAX_CNT_W     = 64;

  // max_val is the all-ones value of the caller's real counter width,
  // zero-extended into the MAX_CNT_W container.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(
    input logic [MAX_CNT_W-1:0] val,
    input logic                 inc,
    input logic [MAX_CNT_W-1:0] max_val
  );
    logic [MAX_CNT_W-1:0] res;
`ifdef BER_COUNT_SAT_EN
    if (inc && (val != max_val)) res = val + MAX_CNT_W'(1);
    else                         res = val;
`else
    res = (val + MAX_CNT_W'(inc)) & max_val;
`endif
    return res;
  endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// ber_ref_delay: reference-bit delay line with a selectable output tap.
//   clock     : system clock (rising edge)
//   i_reset   : synchronous active-low reset; clears the line to 0
//   i_shift   : shift strobe; i_ref_bit enters the line on this edge
//   i_ref_bit : PRBS reference bit from the transmitter
//   i_tap     : selected tap, 0..DELAY_LEN-1
//   o_ref     : reference bit from i_tap strobes ago. Tap 0 is i_ref_bit itself.
// DELAY_LEN must be at least 2.
module ber_ref_delay #(
  parameter  int unsigned DELAY_LEN = ber_pkg::DEF_DELAY_LEN,
  localparam int unsigned TAP_W     = $clog2(DELAY_LEN)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_shift,
  input  logic             i_ref_bit,
  input  logic [TAP_W-1:0] i_tap,
  output logic             o_ref
);

  // line_q[k] holds the reference bit from k+1 strobes ago.
  logic [DELAY_LEN-2:0] line_q;
  logic [DELAY_LEN-1:0] taps;

  // Tap 0 is the live input, so only DELAY_LEN-1 bits of storage are needed.
  assign taps = {line_q, i_ref_bit};

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      line_q <= '0;
    end else if (i_shift) begin
      line_q <= taps[DELAY_LEN-2:0];
    end
  end

  assign o_ref = taps[i_tap];

endmodule

// File: rtl/ber_counter.sv
// ber_counter: per-branch bit-error-rate counter.
// It sweeps the reference delay over taps 0..DELAY_LEN-1 with WINDOW strobes per tap.
// It then locks to the tap with the fewest errors; ties go to the lowest tap.
// After lock it accumulates the compared-bit and error-bit counts.
//   clock       : system clock (rising edge)
//   i_reset     : synchronous active-low reset
//   i_enable    : global enable; the block is frozen while low
//   i_valid     : symbol strobe
//   i_bit       : slicer decision bit
//   i_ref_bit   : PRBS reference bit
//   o_locked    : high once the sweep has completed
//   o_latency   : selected delay tap (0 while searching)
//   o_bit_count : symbols compared since lock
//   o_err_count : mismatches since lock
// Handshake: a symbol is consumed on a rising edge where i_reset, i_enable and i_valid are all high.
//   No ready exists; a symbol presented while i_enable is low is dropped.
// Configuration macro BER_COUNT_SAT_EN: counters saturate when defined, and wrap otherwise.
module ber_counter
  import ber_pkg::*;
#(
  parameter  int unsigned DELAY_LEN = DEF_DELAY_LEN,
  parameter  int unsigned WINDOW    = DEF_WINDOW,
  parameter  int unsigned CNT_W     = DEF_CNT_W,
  localparam int unsigned TAP_W     = $clog2(DELAY_LEN)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_ref_bit,
  output logic             o_locked,
  output logic [TAP_W-1:0] o_latency,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // The width must hold a full-window error count, which can equal WINDOW.
  localparam int unsigned ERR_W = $clog2(WINDOW + 1);

  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [TAP_W-1:0]     TAP_LAST = TAP_W'(DELAY_LEN - 1);
  localparam logic [MAX_CNT_W-1:0] CNT_MAX  = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - CNT_W);

  ber_state_e       state_q;
  logic [TAP_W-1:0] cur_delay_q;
  logic [TAP_W-1:0] best_delay_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [ERR_W-1:0] win_err_q;
  logic [ERR_W-1:0] min_err_q;
  logic             locked_q;
  logic [TAP_W-1:0] latency_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic             strobe;
  logic             ref_tap;
  logic             err;
  logic [ERR_W-1:0] win_result_d;
  logic             new_best;
  logic [TAP_W-1:0] best_delay_d;
  logic [CNT_W-1:0] bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;

  assign strobe = i_reset & i_enable & i_valid;

  ber_ref_delay #(
    .DELAY_LEN (DELAY_LEN)
  ) u_ref_delay (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_shift   (strobe),
    .i_ref_bit (i_ref_bit),
    .i_tap     (cur_delay_q),
    .o_ref     (ref_tap)
  );

  assign err = i_bit ^ ref_tap;

  // The window result includes the error of the current (possibly final) strobe.
  assign win_result_d = win_err_q + ERR_W'(err);
  // A strict compare keeps the earlier, lower tap on ties.
  assign new_best     = (win_result_d < min_err_q);
  // The best tap including this strobe's window is used when the last window closes.
  assign best_delay_d = new_best ? cur_delay_q : best_delay_q;

  assign bit_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(bit_cnt_q), 1'b1, CNT_MAX));
  assign err_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(err_cnt_q), err, CNT_MAX));

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q      <= SEARCH;
      cur_delay_q  <= '0;
      best_delay_q <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      min_err_q    <= '1;
      locked_q     <= 1'b0;
      latency_q    <= '0;
      bit_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else if (strobe) begin
      case (state_q)
        SEARCH: begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
            if (new_best) begin
              min_err_q    <= win_result_d;
              best_delay_q <= cur_delay_q;
            end
            if (cur_delay_q == TAP_LAST) begin
              // The final sweep strobe locks the block but is not counted.
              state_q     <= COUNT;
              cur_delay_q <= best_delay_d;
              locked_q    <= 1'b1;
              latency_q   <= best_delay_d;
            end else begin
              cur_delay_q <= cur_delay_q + TAP_W'(1);
            end
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            win_err_q <= win_result_d;
          end
        end
        COUNT: begin
          bit_cnt_q <= bit_cnt_d;
          err_cnt_q <= err_cnt_d;
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign o_locked    = locked_q;
  assign o_latency   = latency_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_counter.sv
// tb_ber_counter: randomized bench for ber_counter with a behavioural reference model.
// Two instances receive identical stimulus. One uses CNT_W=16 and the other CNT_W=4 for overflow.
// The bench honours BER_COUNT_SAT_EN the same way the design does.
module tb_ber_counter;

  localparam int DL    = 16;
  localparam int WN    = 15;
  localparam int CW    = 16;
  localparam int CW4   = 4;
  localparam int SWEEP = DL * WN;

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst_n = 1'b0;
  logic          en = 1'b0, vld = 1'b0, bit_in = 1'b0, ref_in = 1'b0;
  logic          locked_a, locked_b;
  logic [3:0]    lat_a, lat_b;
  logic [CW-1:0] bits_a, errs_a;
  logic [CW4-1:0] bits_b, errs_b;

  ber_counter #(.DELAY_LEN(DL), .WINDOW(WN), .CNT_W(CW)) dut (
    .clock(clock), .i_reset(rst_n), .i_enable(en), .i_valid(vld),
    .i_bit(bit_in), .i_ref_bit(ref_in),
    .o_locked(locked_a), .o_latency(lat_a),
    .o_bit_count(bits_a), .o_err_count(errs_a)
  );

  ber_counter #(.DELAY_LEN(DL), .WINDOW(WN), .CNT_W(CW4)) dut4 (
    .clock(clock), .i_reset(rst_n), .i_enable(en), .i_valid(vld),
    .i_bit(bit_in), .i_ref_bit(ref_in),
    .o_locked(locked_b), .o_latency(lat_b),
    .o_bit_count(bits_b), .o_err_count(errs_b)
  );

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Records every strobe since reset. At the end of the sweep it scores each tap over its own window.
  bit     ref_hist[$];
  bit     bit_hist[$];
  bit     m_locked;
  int     m_lat;
  longint m_bits, m_errs;

  function automatic bit ref_at(input int j);
    return (j < 0) ? 1'b0 : ref_hist[j];
  endfunction

  task automatic model_reset();
    ref_hist.delete();
    bit_hist.delete();
    m_locked = 1'b0;
    m_lat    = 0;
    m_bits   = 0;
    m_errs   = 0;
  endtask

  task automatic model_strobe(input bit b, input bit r);
    int n, best, min_e, e;
    ref_hist.push_back(r);
    bit_hist.push_back(b);
    n = ref_hist.size();
    if (!m_locked) begin
      if (n == SWEEP) begin
        best  = 0;
        min_e = (1 << $clog2(WN + 1)) - 1;
        for (int d = 0; d < DL; d++) begin
          e = 0;
          for (int k = d * WN; k < (d + 1) * WN; k++)
            e += int'(bit_hist[k] ^ ref_at(k - d));
          if (e < min_e) begin
            min_e = e;
            best  = d;
          end
        end
        m_locked = 1'b1;
        m_lat    = best;
      end
    end else begin
      m_bits++;
      m_errs += longint'(b ^ ref_at(n - 1 - m_lat));
    end
  endtask

  function automatic logic [63:0] exp_cnt(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef BER_COUNT_SAT_EN
    return (c > mx) ? mx : c;
`else
    return c & mx;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_locked"},  64'(locked_a), 64'(m_locked));
    check({tag, "_latency"}, 64'(lat_a),    64'(m_locked ? m_lat : 0));
    check({tag, "_bits"},    64'(bits_a),   exp_cnt(m_bits, CW));
    check({tag, "_errs"},    64'(errs_a),   exp_cnt(m_errs, CW));
    check({tag, "_locked4"}, 64'(locked_b), 64'(m_locked));
    check({tag, "_latency4"},64'(lat_b),    64'(m_locked ? m_lat : 0));
    check({tag, "_bits4"},   64'(bits_b),   exp_cnt(m_bits, CW4));
    check({tag, "_errs4"},   64'(errs_b),   exp_cnt(m_errs, CW4));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge. The model steps on the rising edge. Outputs are sampled 1ns later.
  task automatic cycle(input bit r, input bit e, input bit v, input bit b, input bit rf);
    @(negedge clock);
    rst_n = r; en = e; vld = v; bit_in = b; ref_in = rf;
    @(posedge clock);
    if (!r) model_reset();
    else if (e && v) model_strobe(b, rf);
    #1;
  endtask

  logic [8:0] prbs = 9'h1FF;
  bit         stim_hist[$];

  function automatic bit prbs_next();
    bit fb;
    fb   = prbs[8] ^ prbs[4];
    prbs = {prbs[7:0], fb};
    return fb;
  endfunction

  task automatic do_reset();
    cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    stim_hist.delete();
  endtask

  // One strobe with a PRBS9 reference and i_bit equal to the reference from lat strobes ago.
  task automatic strobe_prbs(input int lat, input bit flip);
    bit r, b;
    int idx;
    r = prbs_next();
    stim_hist.push_back(r);
    idx = stim_hist.size() - 1 - lat;
    b = ((idx >= 0) ? stim_hist[idx] : 1'b0) ^ flip;
    cycle(1'b1, 1'b1, 1'b1, b, r);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int lat, guard, extra;
    bit e, v;
    rst_n = 1'b0;
    model_reset();

    // 1: lock and clean count
    do_reset();
    check_all("reset");
    check("reset_bits_zero", 64'(bits_a), 64'd0);
    repeat (SWEEP - 1) strobe_prbs(5, 1'b0);
    check("s1_prelock", 64'(locked_a), 64'd0);
    strobe_prbs(5, 1'b0);
    check("s1_locked", 64'(locked_a), 64'd1);
    check("s1_latency", 64'(lat_a), 64'd5);
    check("s1_lock_bits", 64'(bits_a), 64'd0);
    check_all("s1_lock");
    repeat (1000) strobe_prbs(5, 1'b0);
    check("s1_bits", 64'(bits_a), 64'd1000);
    check("s1_errs", 64'(errs_a), 64'd0);
    check_all("s1_end");

    // 2: injected errors every 100th counted strobe
    do_reset();
    repeat (SWEEP) strobe_prbs(5, 1'b0);
    for (int c = 1; c <= 1000; c++) strobe_prbs(5, (c % 100) == 0);
    check("s2_bits", 64'(bits_a), 64'd1000);
    check("s2_errs", 64'(errs_a), 64'd10);
    check_all("s2_end");

    // 3: tie-break on constant zeros
    do_reset();
    repeat (SWEEP) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("s3_latency", 64'(lat_a), 64'd0);
    check("s3_locked", 64'(locked_a), 64'd1);
    check_all("s3_end");

    // 4: independent enable / valid gating with random data, through the sweep and into counting
    do_reset();
    guard = 0;
    extra = 0;
    while (extra < 200 && guard < 3000) begin
      e = 1'($urandom);
      v = 1'($urandom);
      cycle(1'b1, e, v, 1'($urandom), 1'($urandom));
      check_all("s4_gate");
      guard++;
      if (m_locked) extra++;
    end
    check("s4_done", 64'(guard < 3000), 64'd1);

    // 5: reset mid-count, then relock
    do_reset();
    repeat (SWEEP) strobe_prbs(5, 1'b0);
    repeat (500) strobe_prbs(5, 1'b0);
    check("s5_bits_before", 64'(bits_a), 64'd500);
    do_reset();
    check("s5_locked_rst", 64'(locked_a), 64'd0);
    check("s5_latency_rst", 64'(lat_a), 64'd0);
    check("s5_bits_rst", 64'(bits_a), 64'd0);
    check("s5_errs_rst", 64'(errs_a), 64'd0);
    repeat (SWEEP - 1) strobe_prbs(5, 1'b0);
    check("s5_prelock", 64'(locked_a), 64'd0);
    strobe_prbs(5, 1'b0);
    check("s5_relock", 64'(locked_a), 64'd1);
    check("s5_relat", 64'(lat_a), 64'd5);
    check_all("s5_end");

    // 6: overflow on the 4-bit instance
    do_reset();
    repeat (SWEEP) strobe_prbs(5, 1'b0);
    repeat (20) strobe_prbs(5, 1'b1);
`ifdef BER_COUNT_SAT_EN
    check("s6_errs4", 64'(errs_b), 64'd15);
    check("s6_bits4", 64'(bits_b), 64'd15);
`else
    check("s6_errs4", 64'(errs_b), 64'd4);
    check("s6_bits4", 64'(bits_b), 64'd4);
`endif
    check("s6_errs16", 64'(errs_a), 64'd20);
    check_all("s6_end");

    // 7: random latencies with random error injection after lock
    for (int it = 0; it < 3; it++) begin
      lat = $urandom_range(0, DL - 1);
      do_reset();
      repeat (SWEEP) strobe_prbs(lat, 1'b0);
      check("s7_latency", 64'(lat_a), 64'(lat));
      check_all("s7_lock");
      repeat (300) strobe_prbs(lat, $urandom_range(0, 15) == 0);
      check_all("s7_end");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ber_counter.md
# ber_counter

Per-branch bit-error-rate counter that sits directly downstream of the phase-select slicer: one instance per branch, I and Q. Consumes the hard decision bit and the transmitter's PRBS reference bit. Sweeps a reference delay line to find the system latency, locks to the delay with fewest errors, then accumulates total-bit and error-bit counts for readout by the host.

## Interface
- DELAY_LEN, 512: reference delay line depth; the sweep covers taps 0..DELAY_LEN-1.
- WINDOW, 511: symbols evaluated per tap during the sweep.
- CNT_W, 64: width of the accumulated bit and error counters.
- clock  input  1  system clock; all logic is on the rising edge.
- i_reset  input  1  reset, synchronous and active-low.
- i_enable  input  1  global clock enable; the block is frozen when low.
- i_valid  input  1  symbol strobe.
- i_bit  input  1  slicer decision bit (sign of the sample).
- i_ref_bit  input  1  PRBS reference bit from the transmitter.
- o_locked  output  1  high once the sweep has completed.
- o_latency  output  clog2(DELAY_LEN)  selected delay tap.
- o_bit_count  output  CNT_W  symbols compared since lock.
- o_err_count  output  CNT_W  mismatches since lock.

## Operation
- Strobe: a cycle with i_reset=1 && i_enable && i_valid. No state changes on any other cycle.
- Reference delay line:
  - Shifts i_ref_bit in on each strobe.
  - Tap d is the reference bit from d strobes earlier; tap 0 is i_ref_bit itself.
- Error definition: err = i_bit XOR tap[cur_delay]. Polarity mapping is fixed by the transmitter and is not inverted here.
- FSM states: SEARCH, COUNT.
- SEARCH:
  - win_cnt runs 0..WINDOW-1; win_err accumulates err for each strobe.
  - On the strobe with win_cnt=WINDOW-1, the window result includes the current err. If the result < min_err (strictly less), set min_err to the result and best_delay to cur_delay.
  - At window end, clear win_cnt and win_err and increment cur_delay.
  - After the window for cur_delay=DELAY_LEN-1: go to COUNT with cur_delay=best_delay.
  - Ties go to the lowest tap.
  - min_err resets to all-ones.
- COUNT:
  - Each strobe increments o_bit_count by 1 and o_err_count by err.
  - The block stays in COUNT until reset. Relock only happens through reset.
- Counter arithmetic: unsigned, CNT_W bits. Overflow behaviour is set by the macro under Configuration.
- Reset (i_reset=0), on the next edge:
  - State=SEARCH, cur_delay=0, best_delay=0, min_err=all-ones.
  - Delay line cleared to 0.
  - o_locked=0, o_latency=0, o_bit_count=0, o_err_count=0.
  - Applies identically mid-sweep or mid-count.

## Timing
- All outputs are registered. Each strobe is reflected in the outputs one cycle after its edge.
- Sweep length: DELAY_LEN*WINDOW strobes.
- o_locked and o_latency update on the edge of the final sweep strobe.
- That final sweep strobe is not counted. The first counted strobe is the next one.
- o_latency holds best_delay from lock until reset. It reads 0 during SEARCH.
- i_enable low on a cycle where i_valid is high: the symbol is dropped, not queued.

## Configuration
- BER_COUNT_SAT_EN:
  - Defined: o_bit_count and o_err_count saturate at 2^CNT_W-1 and hold.
  - Undefined: both counters wrap modulo 2^CNT_W.
  - The two counters saturate independently.

## Structure
- Shared package ber_pkg holds:
  - The state enum: SEARCH, COUNT.
  - Default DELAY_LEN, WINDOW and CNT_W.
  - The macro-guarded saturating-increment function.
- One sub-module, ber_ref_delay:
  - Shift register plus a tap mux indexed by cur_delay.
  - Ports: clock, i_reset, shift strobe, i_ref_bit, i_tap, o_ref.

## Test plan
Bench parameters: DELAY_LEN=16, WINDOW=15, CNT_W=16, unless a scenario says otherwise.
1. Lock and clean count: PRBS9 reference, i_bit = reference delayed 5 strobes.
   - After 240 strobes: o_locked=1, o_latency=5.
   - After 1000 further strobes: o_bit_count=1000, o_err_count=0.
2. Injected errors: as scenario 1, with i_bit inverted on every 100th strobe after lock.
   - After 1000 strobes: o_err_count=10.
3. Tie-break: i_bit=0 and i_ref_bit=0 constant.
   - Every tap scores 0 errors; after 240 strobes: o_latency=0, o_locked=1.
4. Gating: toggle i_enable and i_valid independently, with strobes only when both are high.
   - Counts advance exactly once per both-high cycle.
   - No change when only one is high.
5. Reset mid-count: assert i_reset=0 for one cycle after 500 counted strobes.
   - Next cycle: all outputs 0, o_locked=0.
   - Relock after 240 strobes.
6. Overflow: CNT_W=4, with 20 error strobes after lock.
   - Macro defined: o_err_count=15.
   - Macro undefined: o_err_count=4.
